uart_rx_frame_ctrl: RTL

Receive-side controller between the UART receiver FSM and the consumer. It detects each completed receiver frame (rising edge of the receiver's ready level) and checks parity according to the configured mode. Each frame is queued with its error flag in a small FIFO and delivered over a valid/accept handshake. Sticky parity and overrun status is kept. The block runs in the receiver's baud (16x oversample) clock domain, so no CDC is needed.

---
 rtl/uart_rx_frame_ctrl_if.sv | 22 ++
 rtl/uart_rx_frame_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: consumer-side valid/accept handshake
// carrying the head FIFO entry (data byte and parity-error flag).
interface uart_rx_frame_ctrl_if;
  logic [7:0] dataOut;
  logic       dataErr;
  logic       dataValid;
  logic       dataAccept;

  modport master (
    output dataOut,
    output dataErr,
    output dataValid,
    input  dataAccept
  );

  modport slave (
    input  dataOut,
    input  dataErr,
    input  dataValid,
    output dataAccept
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame capture, parity check and result FIFO.
// Optional RX_FRAME_COUNT_EN adds a 16-bit frameCount output.
module uart_rx_frame_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  baudOut,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            parityMode,
  input  logic [8:0]            dataParityIn,
  input  logic                  rxReady,
  input  logic                  clrErr,
  uart_rx_frame_ctrl_if.master  deq,
  output logic [ADDR_W:0]       fifoCount,
  output logic                  parityErr,
  output logic                  overrunErr
`ifdef RX_FRAME_COUNT_EN
  ,
  output logic [15:0]           frameCount
`endif
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    WAIT,
    CHECK,
    COMMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              rx_d;
  logic [8:0]        word_q;
  logic [1:0]        mode_q;
  logic              perr_q;
  logic              perr_c;
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic capture;
  logic load;
  logic check;
  logic commit;
  logic pop;
  logic push;
  logic drop;

  assign capture = rxReady & ~rx_d & enable;
  assign pop     = deq.dataValid & deq.dataAccept;
  assign push    = commit & ((count < FULL) | pop);
  assign drop    = commit & ~push;

  // State register for the capture/check/commit sequence.
  always_ff @(posedge baudOut) begin
    if (!rst) state_q <= WAIT;
    else      state_q <= state_d;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    check   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (capture) begin
          load    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        check   = 1'b1;
        state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  // Parity verdict on the latched word; mode 11 behaves as none.
  always_comb begin
    perr_c = 1'b0;
    unique case (1'b1)
      mode_q == 2'b01: perr_c = ^word_q;
      mode_q == 2'b10: perr_c = ~^word_q;
      default:         perr_c = 1'b0;
    endcase
  end

  // Edge history, frame latch and parity result.
  // rx_d resets high so a level already high is not an edge.
  always_ff @(posedge baudOut) begin
    if (!rst) begin
      rx_d   <= 1'b1;
      word_q <= '0;
      mode_q <= '0;
      perr_q <= 1'b0;
    end else begin
      rx_d <= rxReady;
      if (load) begin
        word_q <= dataParityIn;
        mode_q <= parityMode;
      end
      if (check) perr_q <= perr_c;
    end
  end

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge baudOut) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {perr_q, word_q[7:0]};
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sticky status; a set event beats a same-cycle clear.
  always_ff @(posedge baudOut) begin
    if (!rst) begin
      parityErr  <= 1'b0;
      overrunErr <= 1'b0;
    end else begin
      if (push && perr_q) parityErr <= 1'b1;
      else if (clrErr)    parityErr <= 1'b0;
      if (drop)           overrunErr <= 1'b1;
      else if (clrErr)    overrunErr <= 1'b0;
    end
  end

`ifdef RX_FRAME_COUNT_EN
  // Counts every captured frame, stored or dropped.
  always_ff @(posedge baudOut) begin
    if (!rst)      frameCount <= '0;
    else if (load) frameCount <= frameCount + 16'd1;
  end
`endif

  assign deq.dataOut   = mem[rd_ptr][7:0];
  assign deq.dataErr   = mem[rd_ptr][8];
  assign deq.dataValid = (count != '0);
  assign fifoCount     = count;

endmodule
